mat_result_serializer: RTL and testbench

Downstream companion to the 2x2 matrix multiplier. It accepts one packed 2x2 result word per frame through a valid/ready handshake. It then streams the four elements out one per handshake beat, in row-major order: [0][0], [0][1], [1][0], [1][1]. It sits between the multiplier's packed result bus and any narrow consumer, such as a UART bridge or memory writer.

---
 rtl/mat_result_serializer_if.sv | 27 ++
 rtl/mat_result_serializer.sv | 76 +++++++
 tb/tb_mat_result_serializer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mat_result_serializer_if.sv
// Stream bundle between the packed-frame producer, the serializer and the element consumer.
// The serializer takes the slave view; the upstream/downstream pair take the master view.
interface mat_result_serializer_if #(
    parameter int ELEM_W = 16,
    parameter int N_ELEM = 4
);
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [ELEM_W*N_ELEM-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [ELEM_W-1:0]        out_data;
    logic [IDX_W-1:0]         out_idx;
    logic                     out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/mat_result_serializer.sv
// Takes one packed 2x2 result frame per handshake and streams its elements out
// row-major ([0][0] first), one per output beat, with zero-bubble frame chaining.
module mat_result_serializer #(
    parameter int ELEM_W = 16,
    parameter int N_ELEM = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mat_result_serializer_if.slave bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      frame_cnt
);
    localparam int IDX_W   = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int FRAME_W = ELEM_W * N_ELEM;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    logic [FRAME_W-1:0] shreg;
    logic [IDX_W-1:0]   idx;
    logic               at_last;
    logic               last_beat;

    // Outputs come only from registered state; in_ready alone looks at out_ready.
    assign at_last       = (state == SEND) && (idx == LAST_IDX);
    assign last_beat     = at_last && bus.out_ready;
    assign bus.in_ready  = (state == IDLE) || last_beat;
    assign bus.out_valid = (state == SEND);
    assign bus.out_data  = shreg[FRAME_W-1 -: ELEM_W];
    assign bus.out_idx   = idx;
    assign bus.out_last  = at_last;
    assign busy          = (state == SEND);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg <= bus.in_data;
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (idx == LAST_IDX) begin
                            frame_cnt <= frame_cnt + 1'b1;
                            idx       <= '0;
                            // A waiting frame chains straight in on the final beat.
                            if (bus.in_valid) begin
                                shreg <= bus.in_data;
                            end else begin
                                shreg <= shreg << ELEM_W;
                                state <= IDLE;
                            end
                        end else begin
                            shreg <= shreg << ELEM_W;
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_result_serializer.sv
// Bench for mat_result_serializer: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the frame/element stream.
module tb_mat_result_serializer;
    localparam int ELEM_W  = 16;
    localparam int N_ELEM  = 4;
    localparam int CNT_W   = 8;
    localparam int FRAME_W = ELEM_W * N_ELEM;

    logic             clk = 1'b0;
    logic             reset;
    logic             busy;
    logic [CNT_W-1:0] frame_cnt;

    mat_result_serializer_if #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) bus ();

    mat_result_serializer #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_beats = 0;

    // Model: frames waiting upstream, and elements of the held frame still to deliver.
    logic [FRAME_W-1:0] src_q[$];
    logic [ELEM_W-1:0]  mq[$];
    logic [CNT_W-1:0]   m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input bit ordy);
        bit                 exp_ready;
        bit                 take;
        bit                 beat;
        logic [FRAME_W-1:0] frame;
        bus.out_ready = ordy;
        bus.in_valid  = (src_q.size() > 0);
        bus.in_data   = (src_q.size() > 0) ? src_q[0] : '0;
        #1;
        exp_ready = (mq.size() == 0) || (mq.size() == 1 && ordy);
        chk("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
        chk("busy", 64'(busy), 64'(mq.size() > 0));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
        if (mq.size() > 0) begin
            chk("out_data", 64'(bus.out_data), 64'(mq[0]));
            chk("out_idx", 64'(bus.out_idx), 64'(N_ELEM - mq.size()));
            chk("out_last", 64'(bus.out_last), 64'(mq.size() == 1));
        end else begin
            chk("out_last_idle", 64'(bus.out_last), 64'd0);
        end
        take = bus.in_valid && exp_ready;
        beat = (mq.size() > 0) && ordy;
        if (beat) begin
            void'(mq.pop_front());
            n_beats++;
            if (mq.size() == 0) m_cnt = m_cnt + 1'b1;
        end
        if (take) begin
            frame = src_q.pop_front();
            for (int e = 0; e < N_ELEM; e++)
                mq.push_back(frame[(N_ELEM-1-e)*ELEM_W +: ELEM_W]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((mq.size() > 0 || src_q.size() > 0) && n < budget) begin
            tick(1'b1);
            n++;
        end
        chk("drain_timeout", 64'(mq.size() + src_q.size()), 64'd0);
    endtask

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        m_cnt         = '0;
        #3;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_idx", 64'(bus.out_idx), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame
        src_q.push_back(64'h0001_0002_0003_0004);
        drain(20);
        tick(1'b1);
        chk("basic_cnt", 64'(frame_cnt), 64'd1);

        // Backpressure on element 0x0002
        src_q.push_back(64'h0001_0002_0003_0004);
        n_beats = 0;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        drain(20);
        chk("bp_beats", 64'(n_beats), 64'd4);

        // Back-to-back frames with in_valid held
        src_q.push_back(64'h1111_2222_3333_4444);
        src_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
        drain(20);
        tick(1'b1);
        chk("b2b_cnt", 64'(frame_cnt), 64'd4);

        // Second frame offered while beat 1 of the first is stalled
        src_q.push_back(64'h0123_4567_89AB_CDEF);
        src_q.push_back(64'hFEDC_BA98_7654_3210);
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        drain(30);
        chk("busy_cnt", 64'(frame_cnt), 64'd6);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0 && src_q.size() < 2)
                src_q.push_back({$urandom, $urandom});
            tick($urandom_range(0, 3) != 0);
        end
        drain(100);

        // Asynchronous reset mid-frame
        src_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
        tick(1'b1);
        tick(1'b1);
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_out_data", 64'(bus.out_data), 64'd0);
        chk("mid_out_idx", 64'(bus.out_idx), 64'd0);
        chk("mid_out_last", 64'(bus.out_last), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_frame_cnt", 64'(frame_cnt), 64'd0);
        mq.delete();
        src_q.delete();
        m_cnt = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        src_q.push_back(64'h0005_0006_0007_0008);
        drain(20);
        chk("post_rst_cnt", 64'(frame_cnt), 64'd1);

        // Counter wrap
        for (int f = 0; f < 254; f++) src_q.push_back({$urandom, $urandom});
        drain(1100);
        chk("cnt_255", 64'(frame_cnt), 64'd255);
        src_q.push_back({$urandom, $urandom});
        drain(20);
        chk("cnt_wrap", 64'(frame_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
